mux_guard: RTL and testbench

- Parametrised successor to the three-channel mux-address conflict guard in the comparator test firmware.
- Guards NCH pulse-injection mux address buses so no two enabled channels ever drive the same mux address.
- Adds a settle hold-off after every address change, per-channel masking, and a sticky flag plus a saturating counter for conflicts.
- Sits between the pulse-sequencer address/enable registers and the analog mux drivers.

---
 rtl/mux_guard_pkg.sv | 16 +
 rtl/mux_conflict_detect.sv | 22 ++
 rtl/mux_guard.sv | 130 +++++++++++++
 tb/tb_mux_guard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mux_guard_pkg.sv
// Shared types and helpers for the mux address conflict guard.
// State encoding is fixed so debug tooling can decode the state register directly.
package mux_guard_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StArmed  = 2'd2
  } mux_state_e;

  // Width needed to hold SETTLE_CYC-1; never narrower than one bit.
  function automatic int unsigned settle_cnt_width(int unsigned settle_cyc);
    return (settle_cyc <= 2) ? 1 : $clog2(settle_cyc);
  endfunction

endpackage

// File: rtl/mux_conflict_detect.sv
// Pairwise address compare across channels; a pair counts only if both channels are enabled.
module mux_conflict_detect #(
  parameter int unsigned NCH  = 3,
  parameter int unsigned ADRW = 4
) (
  input  logic [NCH*ADRW-1:0] adr_i,
  input  logic [NCH-1:0]      msk_i,
  output logic                short_o
);

  always_comb begin
    short_o = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned j = i + 1; j < NCH; j++) begin
        if (msk_i[i] && msk_i[j] && (adr_i[i*ADRW +: ADRW] == adr_i[j*ADRW +: ADRW])) begin
          short_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_guard.sv
// Guards the pulse-injection mux address buses: only conflict-free address sets reach the
// muxes, and the mux enable is held off for a settle period after every address change.
module mux_guard
  import mux_guard_pkg::*;
#(
  parameter int unsigned NCH        = 3,
  parameter int unsigned ADRW       = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CNTW       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NCH*ADRW-1:0] adr_in,
  input  logic [NCH-1:0]      chan_en,
  input  logic                mux_en_in,
  input  logic                clear_stats,
  output logic [NCH*ADRW-1:0] adr_out,
  output logic                mux_en_out,
  output logic                settling,
  output logic                conflict,
  output logic                conflict_sticky,
  output logic [CNTW-1:0]     conflict_cnt
);

  localparam int unsigned CntW = settle_cnt_width(SETTLE_CYC);
  localparam logic [CntW-1:0] Reload = CntW'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
  localparam mux_state_e LoadState = (SETTLE_CYC == 0) ? StArmed : StSettle;

  logic [NCH*ADRW-1:0] adr_q;
  logic                en_q;
  logic [NCH-1:0]      msk_q;
  logic                short;
  logic                chg;
  logic                hit;
  logic                evt;
  mux_state_e          state_q;
  logic [CntW-1:0]     cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adr_q <= '0;
      en_q  <= 1'b0;
      msk_q <= '0;
    end else begin
      adr_q <= adr_in;
      en_q  <= mux_en_in;
      msk_q <= chan_en;
    end
  end

  mux_conflict_detect #(
    .NCH  (NCH),
    .ADRW (ADRW)
  ) u_detect (
    .adr_i   (adr_q),
    .msk_i   (msk_q),
    .short_o (short)
  );

  // Change detection ignores the mask so a masked channel's new address still triggers a settle.
  assign chg = (adr_q != adr_out);
  assign hit = short && en_q;
  assign evt = hit && !conflict;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_out <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_q && !short) begin
            adr_out <= adr_q;
            cnt_q   <= Reload;
            state_q <= LoadState;
          end
        end
        StSettle: begin
          if (!en_q || short) begin
            state_q <= StIdle;
          end else if (chg) begin
            adr_out <= adr_q;
            cnt_q   <= Reload;
          end else if (cnt_q == '0) begin
            state_q <= StArmed;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StArmed: begin
          if (!en_q || short) begin
            state_q <= StIdle;
          end else if (chg) begin
            adr_out <= adr_q;
            cnt_q   <= Reload;
            state_q <= LoadState;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mux_en_out = (state_q == StArmed);
  assign settling   = (state_q == StSettle);

  // A new event in the same cycle as clear_stats restarts the count at one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      conflict <= hit;
      if (evt) begin
        conflict_sticky <= 1'b1;
        if (clear_stats) begin
          conflict_cnt <= CNTW'(1);
        end else if (conflict_cnt != '1) begin
          conflict_cnt <= conflict_cnt + 1'b1;
        end
      end else if (clear_stats) begin
        conflict_sticky <= 1'b0;
        conflict_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_guard.sv
// Scoreboard bench for mux_guard: one instance with default settle, one with zero settle and
// a 4-bit conflict counter.
module tb_mux_guard;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        a_rst_n, b_rst_n;
  logic [11:0] a_adr_in, b_adr_in, a_adr_out, b_adr_out;
  logic [2:0]  a_chen, b_chen;
  logic        a_mux, b_mux, a_clr, b_clr;
  logic        a_en_out, b_en_out, a_set, b_set, a_con, b_con, a_stk, b_stk;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  mux_guard dut_a (
    .clock           (clock),
    .reset_n         (a_rst_n),
    .adr_in          (a_adr_in),
    .chan_en         (a_chen),
    .mux_en_in       (a_mux),
    .clear_stats     (a_clr),
    .adr_out         (a_adr_out),
    .mux_en_out      (a_en_out),
    .settling        (a_set),
    .conflict        (a_con),
    .conflict_sticky (a_stk),
    .conflict_cnt    (a_cnt)
  );

  mux_guard #(
    .NCH        (3),
    .ADRW       (4),
    .SETTLE_CYC (0),
    .CNTW       (4)
  ) dut_b (
    .clock           (clock),
    .reset_n         (b_rst_n),
    .adr_in          (b_adr_in),
    .chan_en         (b_chen),
    .mux_en_in       (b_mux),
    .clear_stats     (b_clr),
    .adr_out         (b_adr_out),
    .mux_en_out      (b_en_out),
    .settling        (b_set),
    .conflict        (b_con),
    .conflict_sticky (b_stk),
    .conflict_cnt    (b_cnt)
  );

  typedef struct {
    int          cyc;
    bit          dut;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] pack(logic [11:0] adr, logic en, logic set, logic con,
                                       logic stk, logic [15:0] cnt);
    return {adr, en, set, con, stk, cnt};
  endfunction

  task automatic push_exp(int c, bit d, logic [11:0] adr, logic en, logic set, logic con,
                          logic stk, logic [15:0] cnt, string name);
    exp_t e;
    e.cyc  = c;
    e.dut  = d;
    e.val  = pack(adr, en, set, con, stk, cnt);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, compares every entry due at this cycle.
  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = e.dut ? pack(b_adr_out, b_en_out, b_set, b_con, b_stk, {12'd0, b_cnt})
                    : pack(a_adr_out, a_en_out, a_set, a_con, a_stk, a_cnt);
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s @%0d: got %h want %h {adr,en,set,con,stk,cnt}",
                   e.name, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_adr_in = '0;  b_adr_in = '0;
    a_chen = '0;    b_chen = '0;
    a_mux = 1'b0;   b_mux = 1'b0;
    a_clr = 1'b0;   b_clr = 1'b0;
    push_exp(1, 0, 12'h000, 0, 0, 0, 0, 16'd0, "reset_a");
    push_exp(1, 1, 12'h000, 0, 0, 0, 0, 16'd0, "reset_b");
    wait_cyc(2);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Stable {2,1,0}: settle on cycles 2..9 after the stimulus, armed at +10.
    wait_cyc(5);
    a_adr_in = 12'h210; a_chen = 3'b111; a_mux = 1'b1;
    push_exp(6,  0, 12'h000, 0, 0, 0, 0, 16'd0, "s1_idle");
    push_exp(7,  0, 12'h210, 0, 1, 0, 0, 16'd0, "s1_settle_first");
    push_exp(14, 0, 12'h210, 0, 1, 0, 0, 16'd0, "s1_settle_last");
    push_exp(15, 0, 12'h210, 1, 0, 0, 0, 16'd0, "s1_armed");

    // Address change without conflict re-enters settle.
    wait_cyc(20);
    a_adr_in = 12'h250;
    push_exp(22, 0, 12'h250, 0, 1, 0, 0, 16'd0, "s2_resettle");
    push_exp(29, 0, 12'h250, 0, 1, 0, 0, 16'd0, "s2_settle_last");
    push_exp(30, 0, 12'h250, 1, 0, 0, 0, 16'd0, "s2_rearmed");

    // ch0 == ch2 == 3 with all channels enabled: conflict, address held.
    wait_cyc(35);
    a_adr_in = 12'h353;
    push_exp(37, 0, 12'h250, 0, 0, 1, 1, 16'd1, "s3_conflict");
    push_exp(40, 0, 12'h250, 0, 0, 1, 1, 16'd1, "s3_no_recount");

    // Masking ch2 removes the conflict; its address still loads.
    wait_cyc(42);
    a_chen = 3'b011;
    push_exp(44, 0, 12'h353, 0, 1, 0, 1, 16'd1, "s4_masked_load");
    push_exp(51, 0, 12'h353, 0, 1, 0, 1, 16'd1, "s4_settle_last");
    push_exp(52, 0, 12'h353, 1, 0, 0, 1, 16'd1, "s4_armed");

    // Zero settle: armed two cycles after valid inputs.
    wait_cyc(60);
    b_adr_in = 12'h210; b_chen = 3'b111; b_mux = 1'b1;
    push_exp(61, 1, 12'h000, 0, 0, 0, 0, 16'd0, "s6_idle");
    push_exp(62, 1, 12'h210, 1, 0, 0, 0, 16'd0, "s6_armed_nosettle");

    wait_cyc(65); b_adr_in = 12'h010;
    push_exp(67, 1, 12'h210, 0, 0, 1, 1, 16'd1, "s5_evt1");
    wait_cyc(67); b_adr_in = 12'h210;
    push_exp(69, 1, 12'h210, 1, 0, 0, 1, 16'd1, "s5_rearm1");
    wait_cyc(69); b_adr_in = 12'h010;
    push_exp(71, 1, 12'h210, 0, 0, 1, 1, 16'd2, "s5_evt2");
    wait_cyc(71); b_adr_in = 12'h210;
    wait_cyc(73); b_adr_in = 12'h010;
    push_exp(75, 1, 12'h210, 0, 0, 1, 1, 16'd3, "s5_evt3");
    wait_cyc(75); b_adr_in = 12'h210;
    push_exp(77, 1, 12'h210, 1, 0, 0, 1, 16'd3, "s5_rearm3");
    wait_cyc(77); b_adr_in = 12'h010;
    wait_cyc(78); b_clr = 1'b1;
    push_exp(79, 1, 12'h210, 0, 0, 1, 1, 16'd1, "s5_clear_vs_evt");
    wait_cyc(79); b_clr = 1'b0;
    wait_cyc(81); b_clr = 1'b1;
    push_exp(82, 1, 12'h210, 0, 0, 1, 0, 16'd0, "s5_clear");
    wait_cyc(82); b_clr = 1'b0;
    wait_cyc(83); b_adr_in = 12'h210;

    // 18 events on a 4-bit counter: saturates at 15.
    for (int i = 0; i < 18; i++) begin
      wait_cyc(85 + 4 * i); b_adr_in = 12'h010;
      push_exp(87 + 4 * i, 1, 12'h210, 0, 0, 1, 1, 16'((i + 1 > 15) ? 15 : i + 1), "s5_sat");
      wait_cyc(87 + 4 * i); b_adr_in = 12'h210;
    end
    push_exp(158, 1, 12'h210, 1, 0, 0, 1, 16'd15, "s6_armed_pre_reset");

    // Reset asserted between edges; outputs must clear before the next edge.
    wait_cyc(160);
    b_rst_n = 1'b0;
    push_exp(160, 1, 12'h000, 0, 0, 0, 0, 16'd0, "s6_async_reset");
    wait_cyc(162);
    b_rst_n = 1'b1;
    push_exp(163, 1, 12'h000, 0, 0, 0, 0, 16'd0, "s6_idle_after_reset");
    push_exp(164, 1, 12'h210, 1, 0, 0, 0, 16'd0, "s6_rearm_after_reset");

    wait_cyc(170);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
